// File: rtl/inert_spi_resp.sv
// SPI responder standing in for the inertial sensor: 16-bit frames, small register file, data-ready INT.
// Define INERT_AUTO_INC_EN to let a held-low SS_n continue into auto-incrementing burst bytes.
module inert_spi_resp #(
    parameter logic [7:0] WHO_AM_I_VAL = 8'h6A,
    parameter logic [7:0] INT_CFG_RST  = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        INT,
    input  logic [15:0] roll_rt,
    input  logic [15:0] yaw_rt,
    input  logic [15:0] ay,
    input  logic [15:0] az,
    input  logic        smpl_vld
);

`ifdef INERT_AUTO_INC_EN
    localparam bit AUTO_INC = 1'b1;
`else
    localparam bit AUTO_INC = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    state_t      state, state_nxt;
    logic        ss_p1, ss_p2, sclk_p1, sclk_p2, sclk_p3, mosi_p1, mosi_p2;
    logic        sclk_rise, sclk_fall, ss_rise;
    logic        cmd_end, byte_end, wr_evt, rw_now;
    logic [4:0]  cnt;
    logic [6:0]  rx;
    logic [7:0]  cmd_byte;
    logic        rw;
    logic [6:0]  addr, rd_addr;
    logic [7:0]  rd_val;
    logic [7:0]  tx;
    logic        skip;
    logic [7:0]  int_cfg, cfg1, cfg2;
    logic [15:0] snap_roll, snap_yaw, snap_ay, snap_az;
    logic [15:0] pend_roll, pend_yaw, pend_ay, pend_az;
    logic        pend_vld, snap_upd, int_q, int_set, int_clr;

    // Input synchronisers; the extra SCLK flop gives the edge detector its history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_p1   <= 1'b1;
            ss_p2   <= 1'b1;
            sclk_p1 <= 1'b1;
            sclk_p2 <= 1'b1;
            sclk_p3 <= 1'b1;
            mosi_p1 <= 1'b0;
            mosi_p2 <= 1'b0;
        end else begin
            ss_p1   <= SS_n;
            ss_p2   <= ss_p1;
            sclk_p1 <= SCLK;
            sclk_p2 <= sclk_p1;
            sclk_p3 <= sclk_p2;
            mosi_p1 <= MOSI;
            mosi_p2 <= mosi_p1;
        end
    end

    assign sclk_rise = !ss_p2 && sclk_p2 && !sclk_p3;
    assign sclk_fall = !ss_p2 && !sclk_p2 && sclk_p3;
    assign ss_rise   = ss_p2 && (state != IDLE);
    assign cmd_byte  = {rx, mosi_p2};
    assign cmd_end   = sclk_rise && (state == CMD) && (cnt == 5'd7);
    assign byte_end  = sclk_rise && (state == DATA) && (cnt == 5'd15);
    assign wr_evt    = byte_end && !rw;
    assign rw_now    = cmd_end ? cmd_byte[7] : rw;
    assign rd_addr   = cmd_end ? cmd_byte[6:0] : addr + 7'd1;

    always_comb begin
        rd_val = 8'h00;
        case (rd_addr)
            7'h0D: rd_val = int_cfg;
            7'h0F: rd_val = WHO_AM_I_VAL;
            7'h10: rd_val = cfg1;
            7'h11: rd_val = cfg2;
            7'h24: rd_val = snap_roll[7:0];
            7'h25: rd_val = snap_roll[15:8];
            7'h26: rd_val = snap_yaw[7:0];
            7'h27: rd_val = snap_yaw[15:8];
            7'h2A: rd_val = snap_ay[7:0];
            7'h2B: rd_val = snap_ay[15:8];
            7'h2C: rd_val = snap_az[7:0];
            7'h2D: rd_val = snap_az[15:8];
            default: rd_val = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (ss_p2) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = CMD;
                CMD:     if (cmd_end) state_nxt = DATA;
                DATA:    if (byte_end) state_nxt = AUTO_INC ? DATA : DONE;
                default: state_nxt = state;
            endcase
        end
    end

    // Frame datapath: bit count, command latch and the outgoing byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= 5'd0;
            rx   <= 7'd0;
            rw   <= 1'b0;
            addr <= 7'd0;
            tx   <= 8'h00;
            skip <= 1'b0;
        end else begin
            if (ss_p2)
                cnt <= 5'd0;
            else if (byte_end && AUTO_INC)
                cnt <= 5'd8;
            else if (sclk_rise && cnt != 5'd16)
                cnt <= cnt + 5'd1;

            if (sclk_rise) rx <= {rx[5:0], mosi_p2};

            if (cmd_end) begin
                rw   <= cmd_byte[7];
                addr <= cmd_byte[6:0];
            end else if (byte_end && AUTO_INC) begin
                addr <= addr + 7'd1;
            end

            // The fall right after a byte load leaves tx alone so its MSB is seen first
            if (cmd_end || (byte_end && AUTO_INC)) begin
                tx   <= rw_now ? rd_val : 8'h00;
                skip <= 1'b1;
            end else if (sclk_fall && state == DATA) begin
                if (skip) skip <= 1'b0;
                else      tx   <= {tx[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_cfg <= INT_CFG_RST;
            cfg1    <= 8'h00;
            cfg2    <= 8'h00;
        end else if (wr_evt) begin
            case (addr)
                7'h0D:   int_cfg <= cmd_byte;
                7'h10:   cfg1    <= cmd_byte;
                7'h11:   cfg2    <= cmd_byte;
                default: ;
            endcase
        end
    end

    // Samples arriving mid-frame wait in the pending buffer until SS_n releases
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_roll <= 16'h0; snap_yaw <= 16'h0; snap_ay <= 16'h0; snap_az <= 16'h0;
            pend_roll <= 16'h0; pend_yaw <= 16'h0; pend_ay <= 16'h0; pend_az <= 16'h0;
            pend_vld  <= 1'b0;
            snap_upd  <= 1'b0;
        end else begin
            snap_upd <= (smpl_vld && ss_p2) || (ss_rise && pend_vld);
            if (smpl_vld && ss_p2) begin
                snap_roll <= roll_rt; snap_yaw <= yaw_rt; snap_ay <= ay; snap_az <= az;
            end else if (ss_rise && pend_vld) begin
                snap_roll <= pend_roll; snap_yaw <= pend_yaw; snap_ay <= pend_ay; snap_az <= pend_az;
            end
            if (smpl_vld && !ss_p2) begin
                pend_roll <= roll_rt; pend_yaw <= yaw_rt; pend_ay <= ay; pend_az <= az;
                pend_vld  <= 1'b1;
            end else if (ss_p2) begin
                pend_vld <= 1'b0;
            end
        end
    end

    assign int_set = snap_upd && int_cfg[1];
    assign int_clr = byte_end && (rw ? (addr == 7'h2D) : (addr == 7'h0D && !cmd_byte[1]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       int_q <= 1'b0;
        else if (int_set) int_q <= 1'b1;
        else if (int_clr) int_q <= 1'b0;
    end

    assign INT  = int_q;
    assign MISO = (state == DATA) && tx[7];

endmodule
